midi_note_rx: RTL and testbench

MIDI_NOTE_RX -- requirements
Module: midi_note_rx

---
 rtl/vsynth_pkg.sv | 28 ++
 rtl/uart_rx_byte.sv | 109 ++++++++++
 rtl/midi_note_rx.sv | 104 ++++++++++
 tb/tb_midi_note_rx.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vsynth_pkg.sv
// Shared MIDI constants and state encodings for the note receiver.
// Holds the status nibbles, the real-time threshold and both FSM enums.
package vsynth_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] RT_THRESHOLD = 8'hF8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_KEY,
        WAIT_VEL
    } parser_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // True for a Note On / Note Off status byte on any channel.
    function automatic logic is_note_status(input logic [7:0] b);
        return (b[7:4] == NOTE_ON) || (b[7:4] == NOTE_OFF);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver for the MIDI line.
// Synchronizes RX, confirms the start bit at half-bit, samples data and
// stop at bit centres; a zero stop bit reports FRAME_ERR and waits for idle.
module uart_rx_byte
    import vsynth_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 31250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    output logic [7:0] DATA,
    output logic       DATA_VALID,
    output logic       FRAME_ERR
);

    localparam int BIT_PERIOD  = CLK_FREQ / BAUD;
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_PERIOD - 1);

    logic             rx_meta;
    logic             rx_sync;
    logic             rx_prev;
    rx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;

    // Two-flop synchronizer plus one delayed copy for falling-edge detection.
    always_ff @(posedge CLK) begin
        if (RST) begin
            // NOTE: preset to idle-high so leaving reset never looks like a start edge.
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Bit-timing state machine: start qualify, data shift, stop check.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            DATA       <= '0;
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            // NOTE: pulses default low each cycle so they can only last one clock.
            DATA_VALID <= 1'b0;
            FRAME_ERR  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        cnt   <= '0;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shift   <= {rx_sync, shift[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_sync) begin
                            DATA       <= shift;
                            DATA_VALID <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            FRAME_ERR <= 1'b1;
                            state     <= RX_WAIT_HIGH;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_sync) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/midi_note_rx.sv
// Monophonic MIDI Note On/Off receiver with running status.
// Optional macro MIDI_CHANNEL_FILTER_EN: accept only voice messages on
// CHANNEL; when undefined the receiver is omni and CHANNEL is ignored.
module midi_note_rx
    import vsynth_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 31250
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX,
    input  logic [3:0] CHANNEL,
    output logic [6:0] NOTE_NUM,
    output logic [6:0] VELOCITY,
    output logic       GATE,
    output logic       NOTE_VALID,
    output logic       FRAME_ERR
);

    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          chan_ok;
    parser_state_t state;
    logic          run_valid;
    logic          run_on;
    logic [6:0]    key;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .DATA       (rx_data),
        .DATA_VALID (rx_valid),
        .FRAME_ERR  (FRAME_ERR)
    );

`ifdef MIDI_CHANNEL_FILTER_EN
    assign chan_ok = (rx_data[3:0] == CHANNEL);
`else
    logic unused_channel;
    assign chan_ok        = 1'b1;
    assign unused_channel = ^CHANNEL;
`endif

    // Message parser: tracks running status and drives the note outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            run_valid  <= 1'b0;
            run_on     <= 1'b0;
            key        <= '0;
            NOTE_NUM   <= '0;
            VELOCITY   <= '0;
            GATE       <= 1'b0;
            NOTE_VALID <= 1'b0;
        end else begin
            NOTE_VALID <= 1'b0;
            if (rx_valid && (rx_data < RT_THRESHOLD)) begin
                if (rx_data[7]) begin
                    if (is_note_status(rx_data) && chan_ok) begin
                        run_valid <= 1'b1;
                        run_on    <= (rx_data[7:4] == NOTE_ON);
                        state     <= WAIT_KEY;
                    end else begin
                        run_valid <= 1'b0;
                        run_on    <= 1'b0;
                        state     <= IDLE;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            if (run_valid) begin
                                key   <= rx_data[6:0];
                                state <= WAIT_VEL;
                            end
                        end
                        WAIT_KEY: begin
                            key   <= rx_data[6:0];
                            state <= WAIT_VEL;
                        end
                        WAIT_VEL: begin
                            state <= WAIT_KEY;
                            if (run_on && (rx_data[6:0] != 7'd0)) begin
                                NOTE_NUM   <= key;
                                VELOCITY   <= rx_data[6:0];
                                GATE       <= 1'b1;
                                NOTE_VALID <= 1'b1;
                            end else if (key == NOTE_NUM) begin
                                GATE       <= 1'b0;
                                NOTE_VALID <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_note_rx.sv
// Self-checking bench for midi_note_rx using a message-level MIDI model.
// Runs at 128 clocks per bit so a 50-clock glitch stays under half a bit.
module tb_midi_note_rx;

    localparam int CLK_FREQ = 12_800_000;
    localparam int BAUD     = 100_000;
    localparam int BITP     = CLK_FREQ / BAUD;
    localparam int GAP      = 4;
    localparam int LAT_NOM  = (BITP * 19) / 2 + 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       RX  = 1'b1;
    logic [3:0] CHANNEL = 4'd2;
    logic [6:0] NOTE_NUM;
    logic [6:0] VELOCITY;
    logic       GATE;
    logic       NOTE_VALID;
    logic       FRAME_ERR;

    midi_note_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX         (RX),
        .CHANNEL    (CHANNEL),
        .NOTE_NUM   (NOTE_NUM),
        .VELOCITY   (VELOCITY),
        .GATE       (GATE),
        .NOTE_VALID (NOTE_VALID),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cycle_cnt = 0;
    int byte_start = 0;
    int nv_cnt = 0;
    int fe_cnt = 0;
    int dv_cnt = 0;
    int nv_off = -1;
    bit check_en = 1'b0;

    // Message-level model state
    logic [7:0] m_status = 8'h00;
    logic [6:0] m_data[$];
    logic [6:0] exp_note = '0;
    logic [6:0] exp_vel  = '0;
    logic       exp_gate = 1'b0;
    int         exp_pulse = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_win(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    endtask

    function automatic bit chan_match(input logic [3:0] ch);
`ifdef MIDI_CHANNEL_FILTER_EN
        return ch == CHANNEL;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_status = 8'h00;
        m_data.delete();
        exp_note = '0;
        exp_vel  = '0;
        exp_gate = 1'b0;
    endtask

    // Apply one received byte; a message completes once two data bytes
    // have been gathered under a valid Note On/Off status.
    task automatic model_byte(input logic [7:0] b);
        logic [6:0] k;
        logic [6:0] v;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            if ((b[7:4] == 4'h8 || b[7:4] == 4'h9) && chan_match(b[3:0])) m_status = b;
            else m_status = 8'h00;
            m_data.delete();
            return;
        end
        if (m_status == 8'h00) return;
        m_data.push_back(b[6:0]);
        if (m_data.size() == 2) begin
            k = m_data[0];
            v = m_data[1];
            m_data.delete();
            if (m_status[7:4] == 4'h9 && v != 7'd0) begin
                exp_note  = k;
                exp_vel   = v;
                exp_gate  = 1'b1;
                exp_pulse = 1;
            end else if (k == exp_note) begin
                exp_gate  = 1'b0;
                exp_pulse = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge CLK);
        cycle_cnt++;
    end

    // Observe outputs just after each rising edge; compare in idle windows.
    initial forever begin
        @(posedge CLK);
        #1;
        if (NOTE_VALID) begin
            nv_cnt++;
            nv_off = cycle_cnt - byte_start;
        end
        if (FRAME_ERR) fe_cnt++;
        if (dut.u_rx.DATA_VALID) dv_cnt++;
        if (check_en) begin
            check("note_num", NOTE_NUM, exp_note);
            check("velocity", VELOCITY, exp_vel);
            check("gate", GATE, exp_gate);
            check("note_valid_idle", NOTE_VALID, 0);
            check("frame_err_idle", FRAME_ERR, 0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        check_en = 1'b0;
        @(negedge CLK);
        byte_start = cycle_cnt;
        nv_cnt = 0;
        fe_cnt = 0;
        dv_cnt = 0;
        nv_off = -1;
        RX = 1'b0;
        repeat (BITP) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = b[i];
            repeat (BITP) @(negedge CLK);
        end
        RX = stop;
        repeat (BITP) @(negedge CLK);
        RX = 1'b1;
        repeat (GAP) @(negedge CLK);
        exp_pulse = 0;
        if (stop) model_byte(b);
        check("nv_count", nv_cnt, exp_pulse);
        if (exp_pulse == 1) check_win("nv_latency", nv_off, LAT_NOM - 2, LAT_NOM + 2);
        check("fe_count", fe_cnt, stop ? 0 : 1);
        check("byte_count", dv_cnt, stop ? 1 : 0);
        check_en = 1'b1;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic send_msg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        send_byte(c, 1'b1);
    endtask

    task automatic do_reset();
        check_en = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        RX  = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        model_reset();
        repeat (GAP) @(negedge CLK);
        check_en = 1'b1;
    endtask

    task automatic expect_out(input string tag, input int n, input int v, input int g);
        @(negedge CLK);
        check({tag, "_note"}, NOTE_NUM, n);
        check({tag, "_vel"}, VELOCITY, v);
        check({tag, "_gate"}, GATE, g);
    endtask

    initial begin
        // Reset state
        RST = 1'b1;
        repeat (5) @(negedge CLK);
        check("rst_note", NOTE_NUM, 0);
        check("rst_vel", VELOCITY, 0);
        check("rst_gate", GATE, 0);
        check("rst_nv", NOTE_VALID, 0);
        check("rst_fe", FRAME_ERR, 0);
        RST = 1'b0;
        model_reset();
        repeat (GAP) @(negedge CLK);
        check_en = 1'b1;

        // Basic Note On
        send_msg(8'h90, 8'h3C, 8'h64);
        expect_out("on1", 60, 100, 1);

        // Running status Note On
        send_byte(8'h40, 1'b1);
        send_byte(8'h50, 1'b1);
        expect_out("run", 64, 80, 1);

        // Note Off for a different key: no change
        send_msg(8'h80, 8'h3C, 8'h00);
        expect_out("off_other", 64, 80, 1);

        // Note On velocity 0 on held key releases gate
        send_msg(8'h90, 8'h40, 8'h00);
        expect_out("off_match", 64, 80, 0);

        // Real-time byte between key and velocity
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        send_byte(8'hF8, 1'b1);
        send_byte(8'h7F, 1'b1);
        expect_out("realtime", 60, 127, 1);

        // Framing error leaves the parser waiting for velocity
        send_byte(8'h90, 1'b1);
        send_byte(8'h3D, 1'b1);
        send_byte(8'h45, 1'b0);
        send_byte(8'h22, 1'b1);
        expect_out("frame_err", 61, 34, 1);

        // 50-clock low glitch must not produce a byte
        check_en = 1'b0;
        @(negedge CLK);
        nv_cnt = 0;
        fe_cnt = 0;
        dv_cnt = 0;
        RX = 1'b0;
        repeat (50) @(negedge CLK);
        RX = 1'b1;
        repeat (2 * BITP) @(negedge CLK);
        check("glitch_bytes", dv_cnt, 0);
        check("glitch_fe", fe_cnt, 0);
        check("glitch_nv", nv_cnt, 0);
        check_en = 1'b1;

        // Other status clears running status; orphan data dropped
        send_byte(8'hB0, 1'b1);
        send_byte(8'h10, 1'b1);
        send_byte(8'h20, 1'b1);
        send_byte(8'h11, 1'b1);
        expect_out("other_status", 61, 34, 1);

        // Reset after the key byte; the velocity byte is then dropped
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        do_reset();
        expect_out("rst_mid_msg", 0, 0, 0);
        send_byte(8'h64, 1'b1);
        expect_out("after_rst", 0, 0, 0);

        // Reset in the middle of a byte
        send_byte(8'h90, 1'b1);
        send_byte(8'h3C, 1'b1);
        check_en = 1'b0;
        @(negedge CLK);
        RX = 1'b0;
        repeat (5 * BITP) @(negedge CLK);
        do_reset();
        send_byte(8'h64, 1'b1);
        expect_out("rst_mid_byte", 0, 0, 0);

        // Channel handling (CHANNEL = 2)
        send_msg(8'h91, 8'h3D, 8'h64);
`ifdef MIDI_CHANNEL_FILTER_EN
        expect_out("chan_other", 0, 0, 0);
`else
        expect_out("chan_omni", 61, 100, 1);
`endif
        send_msg(8'h92, 8'h3C, 8'h64);
        expect_out("chan_match", 60, 100, 1);

        check_en = 1'b0;
        repeat (GAP) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
